// File: rtl/sniff_fifo.sv
// Single-clock capture buffer with drop-on-full, sticky overflow and a
// saturating count of dropped writes for the host.
module sniff_fifo #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write_strobe,
  input  logic [DW-1:0] write_data,
  input  logic          read_strobe,
  output logic [DW-1:0] read_data,
  output logic          read_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clear_overflow,
  output logic [CW-1:0] dropped_count
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvld_q, rvld_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] dcnt_q, dcnt_d;

  logic wr_acc, rd_acc, drop;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    level = wptr_q - rptr_q;
  end

  // Full blocks writes even when a read frees a slot in the same cycle.
  always_comb begin
    wr_acc = write_strobe && !full;
    rd_acc = read_strobe && !empty;
    drop   = write_strobe && full;

    wptr_d  = wr_acc ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_q + (AW+1)'(1) : rptr_q;
    rdata_d = rd_acc ? mem[rptr_q[AW-1:0]] : rdata_q;
    rvld_d  = rd_acc;

    ovf_d  = ovf_q;
    dcnt_d = dcnt_q;
    if (drop) begin
      ovf_d  = 1'b1;
      dcnt_d = clear_overflow ? CW'(1) : sat_inc(dcnt_q);
    end else if (clear_overflow) begin
      ovf_d  = 1'b0;
      dcnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wptr_q[AW-1:0]] <= write_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      ovf_q   <= ovf_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign read_data     = rdata_q;
  assign read_valid    = rvld_q;
  assign overflow      = ovf_q;
  assign dropped_count = dcnt_q;

endmodule

// File: tb/tb_sniff_fifo.sv
// Directed bench for sniff_fifo (AW=2, DW=8, CW=4) with a queue scoreboard.
module tb_sniff_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] write_data = '0;
  logic       read_strobe = 1'b0;
  logic [7:0] read_data;
  logic       read_valid;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic       clear_overflow = 1'b0;
  logic [3:0] dropped_count;

  sniff_fifo #(.AW(2), .DW(8), .CW(4)) dut (
    .clock(clock), .reset(reset),
    .write_strobe(write_strobe), .write_data(write_data),
    .read_strobe(read_strobe), .read_data(read_data), .read_valid(read_valid),
    .empty(empty), .full(full), .level(level),
    .overflow(overflow), .clear_overflow(clear_overflow),
    .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq [$];
  logic       m_ovf = 1'b0;
  logic [3:0] m_dcnt = '0;
  logic [7:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_dcnt  = '0;
    last_rd = '0;
  endtask

  // One clock of stimulus; expectations come from the scoreboard state before the edge.
  task automatic step(input logic ws, input logic [7:0] wd, input logic rs, input logic clr);
    logic m_full, m_empty, rd_acc, wr_acc, drp;
    m_full  = (mq.size() == 4);
    m_empty = (mq.size() == 0);
    rd_acc  = rs && !m_empty;
    wr_acc  = ws && !m_full;
    drp     = ws && m_full;
    if (rd_acc) last_rd = mq.pop_front();
    if (wr_acc) mq.push_back(wd);
    if (drp) begin
      m_ovf  = 1'b1;
      m_dcnt = clr ? 4'd1 : ((m_dcnt == 4'hF) ? m_dcnt : m_dcnt + 4'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_dcnt = '0;
    end
    write_strobe   = ws;
    write_data     = wd;
    read_strobe    = rs;
    clear_overflow = clr;
    @(posedge clock);
    #1;
    write_strobe   = 1'b0;
    read_strobe    = 1'b0;
    clear_overflow = 1'b0;
    chk("read_valid", read_valid, rd_acc);
    chk("read_data", read_data, last_rd);
    chk("level", level, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 4);
    chk("overflow", overflow, m_ovf);
    chk("dropped_count", dropped_count, m_dcnt);
  endtask

  initial begin
    logic [7:0] fill_vals [4];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped_count, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // fill and overflow
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_vals[i], 1'b0, 1'b0);
      chk("fill_level", level, i + 1);
    end
    chk("fill_full", full, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count3", dropped_count, 3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 0);
    chk("clr_count", dropped_count, 0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("clr_drop_ovf", overflow, 1);
    chk("clr_drop_count", dropped_count, 1);

    // drain: stored data untouched by the drops
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", read_data, fill_vals[i]);
      chk("drain_valid", read_valid, 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_read_hold", read_data, 8'h44);

    // simultaneous at empty, then at full
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("sim_empty_level", level, 1);
    chk("sim_empty_valid", read_valid, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("sim_full_data", read_data, 8'hA5);
    chk("sim_full_level", level, 3);
    chk("sim_full_ovf", overflow, 1);

    // asynchronous reset between edges with level 3, overflow 1
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_count", dropped_count, 0);
    chk("mid_rst_valid", read_valid, 0);
    chk("mid_rst_data", read_data, 0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_valid", read_valid, 0);

    // wrap-around with level held at 1
    step(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      chk("wrap_level", level, 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("sat_count", dropped_count, 15);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("sat_hold", dropped_count, 15);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sat_drain", read_data, 8'hC0 + 8'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
